// File: rtl/tmds_pkg.sv
// Shared TMDS lane types and constants: control tokens, reset symbol, tally type.
package tmds_pkg;

    localparam int TALLY_W = 5;

    typedef logic signed [TALLY_W-1:0] tally_t;
    typedef logic [9:0]                tmds_sym_t;

    // Index is {C1,C0}.
    localparam tmds_sym_t CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam tmds_sym_t TMDS_RESET_SYM = 10'b1101010100;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tm_choice.sv
// Transition-minimization stage: picks XOR or XNOR chaining of the pixel byte.
// o_qm[8] is 1 when the XOR chain was used.
module tm_choice
    import tmds_pkg::popcount8;
(
    input  logic [7:0] i_data,
    output logic [8:0] o_qm
);

    function automatic logic [8:0] tm_encode(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [7:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        return {~use_xnor, q};
    endfunction

    always_comb begin
        o_qm = tm_encode(i_data);
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: TM stage into S1 registers, then DC-balance / control-token
// selection in S2. Fixed two-clock latency, one symbol per clock.
module tmds_channel_encoder
    import tmds_pkg::tmds_sym_t;
    import tmds_pkg::CTRL_TOKEN;
    import tmds_pkg::TMDS_RESET_SYM;
    import tmds_pkg::popcount8;
#(
    parameter int TALLY_W = tmds_pkg::TALLY_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic [1:0] i_ctrl,
    input  logic       i_ve,
    output logic [9:0] o_tmds
);

    localparam logic signed [TALLY_W-1:0] TWO = TALLY_W'(2);

    logic [8:0] qm_tm;

    logic       ve_d,   ve_q;
    logic [1:0] ctrl_d, ctrl_q;
    logic [8:0] qm_d,   qm_q;

    tmds_sym_t                  tmds_d,  tmds_q;
    logic signed [TALLY_W-1:0]  tally_d, tally_q;

    logic [3:0]                n1, n0;
    logic signed [TALLY_W-1:0] diff;
    logic                      qm8;

    tm_choice u_tm (
        .i_data (i_data),
        .o_qm   (qm_tm)
    );

    // S1: control fields travel with qm so a ve edge stays aligned with its data.
    always_comb begin
        ve_d   = i_ve;
        ctrl_d = i_ctrl;
        qm_d   = qm_tm;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ve_q   <= 1'b0;
            ctrl_q <= 2'b00;
            qm_q   <= '0;
        end else begin
            ve_q   <= ve_d;
            ctrl_q <= ctrl_d;
            qm_q   <= qm_d;
        end
    end

    // S2: diff is n1-n0 in the tally's signed width; the tally never exceeds +/-10.
    always_comb begin
        qm8     = qm_q[8];
        n1      = popcount8(qm_q[7:0]);
        n0      = 4'd8 - n1;
        diff    = $signed({{(TALLY_W-4){1'b0}}, n1}) - $signed({{(TALLY_W-4){1'b0}}, n0});
        tmds_d  = CTRL_TOKEN[ctrl_q];
        tally_d = '0;
        if (ve_q) begin
            if ((tally_q == '0) || (n1 == n0)) begin
                tmds_d  = {~qm8, qm8, qm8 ? qm_q[7:0] : ~qm_q[7:0]};
                tally_d = qm8 ? (tally_q + diff) : (tally_q - diff);
            end else if ((!tally_q[TALLY_W-1] && (n1 > n0)) ||
                         ( tally_q[TALLY_W-1] && (n0 > n1))) begin
                tmds_d  = {1'b1, qm8, ~qm_q[7:0]};
                tally_d = tally_q - diff + (qm8 ? TWO : '0);
            end else begin
                tmds_d  = {1'b0, qm8, qm_q[7:0]};
                tally_d = tally_q + diff - (qm8 ? '0 : TWO);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmds_q  <= TMDS_RESET_SYM;
            tally_q <= '0;
        end else begin
            tmds_q  <= tmds_d;
            tally_q <= tally_d;
        end
    end

    assign o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: stimulus queues expectations with
// a due cycle, a negedge monitor pops and compares against o_tmds.
module tb_tmds_channel_encoder;

    localparam logic [9:0] RST_SYM = 10'b1101010100;
    localparam logic [9:0] TOK0    = 10'b1101010100;
    localparam logic [9:0] TOK1    = 10'b0010101011;
    localparam logic [9:0] TOK2    = 10'b0101010100;
    localparam logic [9:0] TOK3    = 10'b1010101011;

    logic       clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic [1:0] i_ctrl;
    logic       i_ve;
    logic [9:0] o_tmds;

    typedef struct {
        int         due;
        bit         vid;
        bit         exact;
        logic [9:0] sym;
        logic [7:0] data;
        bit         chk;
        int         tally;
        string      name;
    } item_t;

    item_t sb[$];
    int    cyc       = 0;
    int    n_cmp     = 0;
    int    n_err     = 0;
    int    mon_tally = 0;

    tmds_channel_encoder dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_ctrl  (i_ctrl),
        .i_ve    (i_ve),
        .o_tmds  (o_tmds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic int disp(input logic [9:0] s);
        int c;
        c = 0;
        for (int i = 0; i < 10; i++) c += int'(s[i]);
        return 2 * c - 10;
    endfunction

    task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit vid, input bit exact, input logic [9:0] sym,
                        input logic [7:0] d, input bit chk, input int tally, input string name);
        item_t it;
        it.due   = cyc + 2;
        it.vid   = vid;
        it.exact = exact;
        it.sym   = sym;
        it.data  = d;
        it.chk   = chk;
        it.tally = tally;
        it.name  = name;
        sb.push_back(it);
    endtask

    task automatic drive(input logic ve, input logic [1:0] c, input logic [7:0] d,
                         input bit vid, input bit exact, input logic [9:0] sym,
                         input bit chk, input int tally, input string name);
        @(posedge clk);
        #1;
        i_ve   = ve;
        i_ctrl = c;
        i_data = d;
        push(vid, exact, sym, d, chk, tally, name);
    endtask

    task automatic ctl(input logic [1:0] c, input logic [9:0] sym, input string name);
        drive(1'b0, c, 8'($urandom_range(0, 255)), 1'b0, 1'b1, sym, 1'b0, 0, name);
    endtask

    task automatic vid(input logic [7:0] d, input logic [9:0] sym, input int tally, input string name);
        drive(1'b1, 2'($urandom_range(0, 3)), d, 1'b1, 1'b1, sym, 1'b1, tally, name);
    endtask

    // Monitor
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (!i_rst_n) mon_tally = 0;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                if (it.exact) check_sym(it.name, o_tmds, it.sym);
                if (it.vid) mon_tally += disp(o_tmds);
                else        mon_tally = 0;
                if (!it.exact) begin
                    check_int({it.name, "_decode"}, int'(ref_decode(o_tmds)), int'(it.data));
                    n_cmp++;
                    if (mon_tally > 10 || mon_tally < -10) begin
                        n_err++;
                        $display("FAIL %s_bound: tally %0d outside -10..10 (cycle %0d)",
                                 it.name, mon_tally, cyc);
                    end
                end
                if (it.chk) check_int({it.name, "_tally"}, mon_tally, it.tally);
            end
        end
    end

    // Stimulus
    initial begin
        i_rst_n = 1'b0;
        i_ve    = 1'b0;
        i_ctrl  = 2'b00;
        i_data  = 8'h00;

        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'b0, 1'b1, RST_SYM, 1'b0, 0, "rst_hold");
        end
        drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, RST_SYM, 1'b0, 0, "rst_release");
        @(negedge clk);
        i_rst_n = 1'b1;

        ctl(2'b00, TOK0, "ctrl00");
        ctl(2'b01, TOK1, "ctrl01");
        ctl(2'b10, TOK2, "ctrl10");
        ctl(2'b11, TOK3, "ctrl11");

        vid(8'h00, 10'h100, -8, "disp0");
        vid(8'h00, 10'h3FF,  2, "disp1");
        vid(8'h00, 10'h100, -6, "disp2");

        ctl(2'b00, TOK0, "edge_ctrl");
        vid(8'hFF, 10'h200, -8, "ff_a");
        vid(8'hFF, 10'h0FF, -2, "ff_c1");
        vid(8'hFF, 10'h0FF,  4, "ff_c2");
        vid(8'hFF, 10'h200, -4, "ff_b");
        ctl(2'b00, TOK0, "v2c_ctrl");
        vid(8'hFF, 10'h200, -8, "c2v_ff");

        ctl(2'b01, TOK1, "tog_c1");
        vid(8'h00, 10'h100, -8, "tog_v1");
        ctl(2'b10, TOK2, "tog_c2");
        vid(8'h00, 10'h100, -8, "tog_v2");
        ctl(2'b11, TOK3, "tog_c3");
        vid(8'h0F, 10'h105, -4, "xor_0f");

        for (int i = 0; i < 10000; i++) begin
            drive(1'b1, 2'b00, 8'($urandom_range(0, 255)), 1'b1, 1'b0, '0, 1'b0, 0, "soak");
        end

        ctl(2'b00, TOK0, "pre_rst_ctrl");
        vid(8'h00, 10'h100, -8, "pre_rst_v0");
        vid(8'h00, 10'h3FF,  2, "pre_rst_v1");
        vid(8'h00, 10'h100, -6, "pre_rst_v2");
        @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check_sym("async_rst", o_tmds, RST_SYM);
        @(posedge clk);
        #1;
        check_sym("rst_held", o_tmds, RST_SYM);
        @(negedge clk);
        #1;
        i_rst_n = 1'b1;
        push(1'b1, 1'b1, 10'h100, 8'h00, 1'b1, -8, "post_rst_v0");
        vid(8'h00, 10'h3FF, 2, "post_rst_v1");
        ctl(2'b00, TOK0, "final_ctrl");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected symbols never compared", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
